// File: rtl/faux_hd_h2d_fis_parser.sv
// faux_hd_h2d_fis_parser: host-to-device FIS parser behind a link-layer read port.
// Decodes register FISes into shadow registers, commits them on a CRC-good
// 5-dword frame, forwards data-FIS payload with one cycle of latency, and
// reports exactly one result pulse per terminated frame.
// Optional build macro: FAUX_HD_PM_FILTER_EN (reject register FISes whose
// port-multiplier field differs from PORT_MULT).
//
// state     | meaning
// IDLE      | waiting for frame start, ll_read_ready high
// HEADER    | waiting for DW0, FIS type decode
// REG_BODY  | storing register FIS DW1..DW4
// DATA_BODY | forwarding data FIS payload
// DISCARD   | unknown FIS type, counting dwords until frame end
// WAIT_END  | register FIS complete, counting extra dwords until frame end
module faux_hd_h2d_fis_parser #(
  parameter int         MAX_DATA_DWORDS = 2048,
  parameter logic [3:0] PORT_MULT       = 4'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ll_read_start,
  input  logic        ll_read_strobe,
  input  logic [31:0] ll_read_data,
  input  logic        ll_read_finished,
  input  logic        ll_read_crc_ok,
  output logic        ll_read_ready,
  output logic        h2d_reg_stb,
  output logic        h2d_data_stb,
  output logic [7:0]  h2d_command,
  output logic [15:0] h2d_features,
  output logic        h2d_cmd_bit,
  output logic [3:0]  h2d_port_mult,
  output logic [7:0]  h2d_control,
  output logic [7:0]  h2d_device,
  output logic [47:0] h2d_lba,
  output logic [15:0] h2d_sector_count,
  output logic        cl_of_strobe,
  output logic [31:0] cl_of_data,
  output logic        read_crc_fail,
  output logic        frame_error_stb,
  output logic [3:0]  parser_state
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] HEADER    = 4'd1;
  localparam logic [3:0] REG_BODY  = 4'd2;
  localparam logic [3:0] DATA_BODY = 4'd3;
  localparam logic [3:0] DISCARD   = 4'd4;
  localparam logic [3:0] WAIT_END  = 4'd5;

`ifdef FAUX_HD_PM_FILTER_EN
  localparam bit PM_FILTER = 1'b1;
`else
  localparam bit PM_FILTER = 1'b0;
`endif

  logic [3:0]  state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic        ovf_q, ovf_d;

  // shadow copy of the register FIS, committed to the h2d_* outputs on success
  logic [7:0]  sh_cmd_q, sh_cmd_d;
  logic [15:0] sh_feat_q, sh_feat_d;
  logic        sh_c_q, sh_c_d;
  logic [3:0]  sh_pm_q, sh_pm_d;
  logic [7:0]  sh_ctrl_q, sh_ctrl_d;
  logic [7:0]  sh_dev_q, sh_dev_d;
  logic [47:0] sh_lba_q, sh_lba_d;
  logic [15:0] sh_sc_q, sh_sc_d;

  logic [7:0]  cmd_q, cmd_d;
  logic [15:0] feat_q, feat_d;
  logic        c_q, c_d;
  logic [3:0]  pm_q, pm_d;
  logic [7:0]  ctrl_q, ctrl_d;
  logic [7:0]  dev_q, dev_d;
  logic [47:0] lba_q, lba_d;
  logic [15:0] sc_q, sc_d;

  logic        reg_stb_q, reg_stb_d;
  logic        data_stb_q, data_stb_d;
  logic        crc_fail_q, crc_fail_d;
  logic        ferr_q, ferr_d;
  logic        of_stb_q, of_stb_d;
  logic [31:0] of_data_q, of_data_d;

  logic        pm_ok;
  logic [11:0] cnt_inc;

  assign pm_ok   = !PM_FILTER || (sh_pm_q == PORT_MULT);
  assign cnt_inc = (cnt_q == 12'hFFF) ? cnt_q : cnt_q + 12'd1;

  // frame sequencing: dword processing first, then termination or abort
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    sh_cmd_d   = sh_cmd_q;
    sh_feat_d  = sh_feat_q;
    sh_c_d     = sh_c_q;
    sh_pm_d    = sh_pm_q;
    sh_ctrl_d  = sh_ctrl_q;
    sh_dev_d   = sh_dev_q;
    sh_lba_d   = sh_lba_q;
    sh_sc_d    = sh_sc_q;
    cmd_d      = cmd_q;
    feat_d     = feat_q;
    c_d        = c_q;
    pm_d       = pm_q;
    ctrl_d     = ctrl_q;
    dev_d      = dev_q;
    lba_d      = lba_q;
    sc_d       = sc_q;
    reg_stb_d  = 1'b0;
    data_stb_d = 1'b0;
    crc_fail_d = 1'b0;
    ferr_d     = 1'b0;
    of_stb_d   = 1'b0;
    of_data_d  = of_data_q;

    if (state_q == IDLE) begin
      if (ll_read_start) begin
        state_d = HEADER;
        cnt_d   = 12'd0;
        ovf_d   = 1'b0;
      end
    end else if (ll_read_start) begin
      // a new start mid-frame aborts the old frame without committing
      ferr_d  = 1'b1;
      state_d = HEADER;
      cnt_d   = 12'd0;
      ovf_d   = 1'b0;
    end else begin
      if (ll_read_strobe) begin
        cnt_d = cnt_inc;
        case (state_q)
          HEADER: begin
            sh_pm_d        = ll_read_data[11:8];
            sh_c_d         = ll_read_data[15];
            sh_cmd_d       = ll_read_data[23:16];
            sh_feat_d[7:0] = ll_read_data[31:24];
            case (ll_read_data[7:0])
              8'h27:   state_d = REG_BODY;
              8'h46:   state_d = DATA_BODY;
              default: state_d = DISCARD;
            endcase
          end
          REG_BODY: begin
            case (cnt_q)
              12'd1: begin
                sh_lba_d[23:0] = ll_read_data[23:0];
                sh_dev_d       = ll_read_data[31:24];
              end
              12'd2: begin
                sh_lba_d[47:24] = ll_read_data[23:0];
                sh_feat_d[15:8] = ll_read_data[31:24];
              end
              12'd3: begin
                sh_sc_d   = ll_read_data[15:0];
                sh_ctrl_d = ll_read_data[31:24];
              end
              default: ;
            endcase
            if (cnt_q == 12'd4) state_d = WAIT_END;
          end
          DATA_BODY: begin
            // cnt_q includes the header dword, so it equals the payload index + 1
            if (int'(cnt_q) <= MAX_DATA_DWORDS) begin
              of_stb_d  = 1'b1;
              of_data_d = ll_read_data;
            end else begin
              ovf_d = 1'b1;
            end
          end
          default: ;
        endcase
      end

      if (ll_read_finished) begin
        if (!ll_read_crc_ok) begin
          crc_fail_d = 1'b1;
        end else if ((state_d == REG_BODY || state_d == WAIT_END) &&
                     cnt_d == 12'd5 && pm_ok) begin
          cmd_d     = sh_cmd_d;
          feat_d    = sh_feat_d;
          c_d       = sh_c_d;
          pm_d      = sh_pm_d;
          ctrl_d    = sh_ctrl_d;
          dev_d     = sh_dev_d;
          lba_d     = sh_lba_d;
          sc_d      = sh_sc_d;
          reg_stb_d = 1'b1;
        end else if (state_d == DATA_BODY && !ovf_d) begin
          data_stb_d = 1'b1;
        end else begin
          ferr_d = 1'b1;
        end
        state_d = IDLE;
      end
    end
  end

  // state, shadow and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 12'd0;
      ovf_q      <= 1'b0;
      sh_cmd_q   <= '0;
      sh_feat_q  <= '0;
      sh_c_q     <= 1'b0;
      sh_pm_q    <= '0;
      sh_ctrl_q  <= '0;
      sh_dev_q   <= '0;
      sh_lba_q   <= '0;
      sh_sc_q    <= '0;
      cmd_q      <= '0;
      feat_q     <= '0;
      c_q        <= 1'b0;
      pm_q       <= '0;
      ctrl_q     <= '0;
      dev_q      <= '0;
      lba_q      <= '0;
      sc_q       <= '0;
      reg_stb_q  <= 1'b0;
      data_stb_q <= 1'b0;
      crc_fail_q <= 1'b0;
      ferr_q     <= 1'b0;
      of_stb_q   <= 1'b0;
      of_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      sh_cmd_q   <= sh_cmd_d;
      sh_feat_q  <= sh_feat_d;
      sh_c_q     <= sh_c_d;
      sh_pm_q    <= sh_pm_d;
      sh_ctrl_q  <= sh_ctrl_d;
      sh_dev_q   <= sh_dev_d;
      sh_lba_q   <= sh_lba_d;
      sh_sc_q    <= sh_sc_d;
      cmd_q      <= cmd_d;
      feat_q     <= feat_d;
      c_q        <= c_d;
      pm_q       <= pm_d;
      ctrl_q     <= ctrl_d;
      dev_q      <= dev_d;
      lba_q      <= lba_d;
      sc_q       <= sc_d;
      reg_stb_q  <= reg_stb_d;
      data_stb_q <= data_stb_d;
      crc_fail_q <= crc_fail_d;
      ferr_q     <= ferr_d;
      of_stb_q   <= of_stb_d;
      of_data_q  <= of_data_d;
    end
  end

  assign ll_read_ready    = (state_q == IDLE);
  assign h2d_reg_stb      = reg_stb_q;
  assign h2d_data_stb     = data_stb_q;
  assign h2d_command      = cmd_q;
  assign h2d_features     = feat_q;
  assign h2d_cmd_bit      = c_q;
  assign h2d_port_mult    = pm_q;
  assign h2d_control      = ctrl_q;
  assign h2d_device       = dev_q;
  assign h2d_lba          = lba_q;
  assign h2d_sector_count = sc_q;
  assign cl_of_strobe     = of_stb_q;
  assign cl_of_data       = of_data_q;
  assign read_crc_fail    = crc_fail_q;
  assign frame_error_stb  = ferr_q;
  assign parser_state     = state_q;

endmodule

// File: tb/tb_faux_hd_h2d_fis_parser.sv
// Directed bench for faux_hd_h2d_fis_parser with a scoreboard of expected
// result pulses, committed field sets and forwarded payload dwords.
module tb_faux_hd_h2d_fis_parser;

  localparam int MAXD = 2048;
  localparam int R_REG = 1, R_DATA = 2, R_CRC = 3, R_ERR = 4;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [15:0] feat;
    logic        c;
    logic [3:0]  pm;
    logic [7:0]  ctrl;
    logic [7:0]  dev;
    logic [47:0] lba;
    logic [15:0] sc;
  } fields_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ll_read_start = 1'b0;
  logic        ll_read_strobe = 1'b0;
  logic [31:0] ll_read_data = '0;
  logic        ll_read_finished = 1'b0;
  logic        ll_read_crc_ok = 1'b0;
  logic        ll_read_ready;
  logic        h2d_reg_stb, h2d_data_stb;
  logic [7:0]  h2d_command;
  logic [15:0] h2d_features;
  logic        h2d_cmd_bit;
  logic [3:0]  h2d_port_mult;
  logic [7:0]  h2d_control, h2d_device;
  logic [47:0] h2d_lba;
  logic [15:0] h2d_sector_count;
  logic        cl_of_strobe;
  logic [31:0] cl_of_data;
  logic        read_crc_fail, frame_error_stb;
  logic [3:0]  parser_state;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  int          exp_res_q[$];
  fields_t     exp_fld_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] fq[$];
  fields_t     cur = '0;
  fields_t     dut_fld;
  int          n_res, code, e;

  always #5 clk = ~clk;

  faux_hd_h2d_fis_parser #(.MAX_DATA_DWORDS(MAXD), .PORT_MULT(4'h0)) dut (
    .clk(clk), .rst(rst),
    .ll_read_start(ll_read_start), .ll_read_strobe(ll_read_strobe),
    .ll_read_data(ll_read_data), .ll_read_finished(ll_read_finished),
    .ll_read_crc_ok(ll_read_crc_ok), .ll_read_ready(ll_read_ready),
    .h2d_reg_stb(h2d_reg_stb), .h2d_data_stb(h2d_data_stb),
    .h2d_command(h2d_command), .h2d_features(h2d_features),
    .h2d_cmd_bit(h2d_cmd_bit), .h2d_port_mult(h2d_port_mult),
    .h2d_control(h2d_control), .h2d_device(h2d_device),
    .h2d_lba(h2d_lba), .h2d_sector_count(h2d_sector_count),
    .cl_of_strobe(cl_of_strobe), .cl_of_data(cl_of_data),
    .read_crc_fail(read_crc_fail), .frame_error_stb(frame_error_stb),
    .parser_state(parser_state)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  assign dut_fld = {h2d_command, h2d_features, h2d_cmd_bit, h2d_port_mult,
                    h2d_control, h2d_device, h2d_lba, h2d_sector_count};

  // output monitor: pops the scoreboard whenever the DUT produces something
  always @(negedge clk) begin
    if (mon_en) begin
      n_res = int'(h2d_reg_stb) + int'(h2d_data_stb) + int'(read_crc_fail) + int'(frame_error_stb);
      if (n_res != 0) begin
        chk("result_onehot", 128'(n_res), 128'(1));
        code = h2d_reg_stb ? R_REG : h2d_data_stb ? R_DATA : read_crc_fail ? R_CRC : R_ERR;
        if (exp_res_q.size() == 0) begin
          chk("unexpected_result", 128'(n_res), 128'(0));
        end else begin
          e = exp_res_q.pop_front();
          chk("result_type", 128'(code), 128'(e));
          if (e == R_REG && exp_fld_q.size() != 0) cur = exp_fld_q.pop_front();
          chk("h2d_fields", 128'(dut_fld), 128'(cur));
        end
      end
      if (cl_of_strobe) begin
        if (exp_data_q.size() == 0) chk("unexpected_payload", 128'(cl_of_strobe), 128'(0));
        else chk("payload_data", 128'(cl_of_data), 128'(exp_data_q.pop_front()));
      end
    end
  end

  task automatic send_frame(input bit crc, input bit fin_last);
    @(posedge clk); #1; ll_read_start = 1'b1;
    @(posedge clk); #1; ll_read_start = 1'b0;
    for (int i = 0; i < fq.size(); i++) begin
      ll_read_strobe = 1'b1;
      ll_read_data   = fq[i];
      if (fin_last && i == fq.size() - 1) begin
        ll_read_finished = 1'b1;
        ll_read_crc_ok   = crc;
      end
      @(posedge clk); #1;
    end
    ll_read_strobe   = 1'b0;
    ll_read_finished = 1'b0;
    if (!fin_last || fq.size() == 0) begin
      ll_read_finished = 1'b1;
      ll_read_crc_ok   = crc;
      @(posedge clk); #1;
      ll_read_finished = 1'b0;
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic send_partial();
    @(posedge clk); #1; ll_read_start = 1'b1;
    @(posedge clk); #1; ll_read_start = 1'b0;
    for (int i = 0; i < fq.size(); i++) begin
      ll_read_strobe = 1'b1;
      ll_read_data   = fq[i];
      @(posedge clk); #1;
    end
    ll_read_strobe = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 50 && (exp_res_q.size() != 0 || exp_data_q.size() != 0); i++)
      @(posedge clk);
    @(negedge clk);
    chk({tag, "_results_left"}, 128'(exp_res_q.size()), 128'(0));
    chk({tag, "_payload_left"}, 128'(exp_data_q.size()), 128'(0));
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 128'(parser_state), 128'(0));
    chk("rst_fields", 128'(dut_fld), 128'(0));
    chk("rst_strobes", 128'({h2d_reg_stb, h2d_data_stb, cl_of_strobe, read_crc_fail, frame_error_stb}), 128'(0));
    #1; rst = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 128'(ll_read_ready), 128'(1));

    // strobes in IDLE are ignored
    @(posedge clk); #1; ll_read_strobe = 1'b1; ll_read_data = 32'h0000_0027;
    repeat (3) @(posedge clk);
    #1; ll_read_strobe = 1'b0;
    @(negedge clk);
    chk("idle_strobe_state", 128'(parser_state), 128'(0));

    // register FIS, C=1, READ DMA EXT
    fq = '{32'h0025_8027, 32'h4000_1000, 32'h0000_0000, 32'h0000_0008, 32'h0000_0000};
    exp_res_q.push_back(R_REG);
    exp_fld_q.push_back('{cmd: 8'h25, feat: 16'h0000, c: 1'b1, pm: 4'h0, ctrl: 8'h00,
                          dev: 8'h40, lba: 48'h0000_0000_1000, sc: 16'h0008});
    send_frame(1'b1, 1'b0);
    drain("reg_fis");
    chk("ready_after_frame", 128'(ll_read_ready), 128'(1));

    // data FIS with 128 payload dwords
    fq = '{32'h0000_0046};
    for (int i = 0; i < 128; i++) begin
      fq.push_back(32'(i));
      exp_data_q.push_back(32'(i));
    end
    exp_res_q.push_back(R_DATA);
    send_frame(1'b1, 1'b0);
    drain("data_fis");

    // register FIS with bad CRC leaves fields untouched
    fq = '{32'h0735_8027, 32'hE0AB_CDEF, 32'h0F12_3456, 32'h0800_00FF, 32'h0000_0000};
    exp_res_q.push_back(R_CRC);
    send_frame(1'b0, 1'b0);
    drain("reg_crc_bad");

    // short register FIS and unknown type
    fq = '{32'h0025_8027, 32'h4000_1000, 32'h0000_0000, 32'h0000_0008};
    exp_res_q.push_back(R_ERR);
    send_frame(1'b1, 1'b0);
    fq = '{32'h0000_0039, 32'h1111_1111, 32'h2222_2222};
    exp_res_q.push_back(R_ERR);
    send_frame(1'b1, 1'b0);
    drain("bad_len_type");

    // zero-dword frame
    fq = {};
    exp_res_q.push_back(R_ERR);
    send_frame(1'b1, 1'b0);
    drain("zero_dwords");

    // 6-dword register FIS is the wrong length
    fq = '{32'h0025_8027, 32'h4000_1000, 32'h0, 32'h8, 32'h0, 32'h0};
    exp_res_q.push_back(R_ERR);
    send_frame(1'b1, 1'b0);
    drain("reg_too_long");

    // data FIS overflowing the maximum payload
    fq = '{32'h0000_0046};
    for (int i = 0; i < MAXD + 3; i++) begin
      fq.push_back(32'(i + 32'h1000));
      if (i < MAXD) exp_data_q.push_back(32'(i + 32'h1000));
    end
    exp_res_q.push_back(R_ERR);
    send_frame(1'b1, 1'b0);
    drain("data_overflow");

    // control FIS, C=0, SRST set, finished together with the last dword
    fq = '{32'h1100_0327, 32'hA078_9ABC, 32'h2212_3456, 32'h0400_0102, 32'h0000_0000};
`ifdef FAUX_HD_PM_FILTER_EN
    exp_res_q.push_back(R_ERR);
`else
    exp_res_q.push_back(R_REG);
    exp_fld_q.push_back('{cmd: 8'h00, feat: 16'h2211, c: 1'b0, pm: 4'h3, ctrl: 8'h04,
                          dev: 8'hA0, lba: 48'h1234_5678_9ABC, sc: 16'h0102});
`endif
    send_frame(1'b1, 1'b1);
    drain("ctrl_fis");

    // abort by a new start, then a good register FIS
    fq = '{32'h0025_8027, 32'h4000_1000};
    exp_res_q.push_back(R_ERR);
    send_partial();
    fq = '{32'h0024_8027, 32'h4100_2000, 32'h0000_0000, 32'h0000_0010, 32'h0000_0000};
    exp_res_q.push_back(R_REG);
    exp_fld_q.push_back('{cmd: 8'h24, feat: 16'h0000, c: 1'b1, pm: 4'h0, ctrl: 8'h00,
                          dev: 8'h41, lba: 48'h0000_0000_2000, sc: 16'h0010});
    send_frame(1'b1, 1'b0);
    drain("abort");

    // reset in the middle of a data frame: no result pulse
    fq = '{32'h0000_0046, 32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003};
    exp_data_q.push_back(32'hAAAA_0001);
    exp_data_q.push_back(32'hAAAA_0002);
    exp_data_q.push_back(32'hAAAA_0003);
    send_partial();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_state", 128'(parser_state), 128'(0));
    chk("mid_rst_ready", 128'(ll_read_ready), 128'(1));
    chk("mid_rst_fields", 128'(dut_fld), 128'(0));
    cur = '0;
    repeat (5) @(posedge clk);
    drain("mid_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
